// File: rtl/pipe_load_ctrl.sv
// Handshake controller for an N-stage delay-line pipeline: per-stage load enables
// with bubble collapsing, flush, occupancy tracking and a saturating stall counter.
module pipe_load_ctrl #(
    parameter int PIPELINE_STAGE  = 5,
    parameter int OCC_WIDTH       = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    input  logic                       flush_i,
    output logic [PIPELINE_STAGE-1:0]  pipeLoad_en_o,
    output logic [PIPELINE_STAGE-1:0]  stage_valid_o,
    output logic [OCC_WIDTH-1:0]       occupancy_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);
    localparam int N = PIPELINE_STAGE;

    logic [N-1:0]               valid_q, valid_d;
    logic [N-1:0]               rdy;
    logic [N-1:0]               up_v;
    logic [N-1:0]               en;
    logic [OCC_WIDTH-1:0]       occ_q, occ_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       block;

    // Nothing moves while reset or flush is asserted.
    assign block = rst | flush_i;

    // Ready ripples back from the output so an empty stage always accepts.
    always_comb begin
        rdy        = '0;
        rdy[N-1]   = out_ready_i | ~valid_q[N-1];
        for (int k = N - 2; k >= 0; k--) begin
            rdy[k] = ~valid_q[k] | rdy[k+1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign up_v[gi] = in_valid_i;
        end else begin : g_body
            assign up_v[gi] = valid_q[gi-1];
        end
        assign en[gi]      = rdy[gi] & up_v[gi] & ~block;
        assign valid_d[gi] = flush_i ? 1'b0 : (rdy[gi] ? up_v[gi] : valid_q[gi]);
    end

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < N; k++) begin
            occ_d = occ_d + OCC_WIDTH'(valid_d[k]);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!flush_i && valid_q[N-1] && !out_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    assign pipeLoad_en_o = en;
    assign in_ready_o    = rdy[0] & ~block;
    assign out_valid_o   = valid_q[N-1] & ~rst;
    assign stage_valid_o = valid_q;
    assign occupancy_o   = occ_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_pipe_load_ctrl.sv
// Directed bench for pipe_load_ctrl (N=5, 4-bit stall counter) with hand-computed expectations.
module tb_pipe_load_ctrl;
    localparam int N  = 5;
    localparam int OW = 3;
    localparam int SW = 4;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          out_ready_i;
    logic          out_valid_o;
    logic          flush_i;
    logic [N-1:0]  pipeLoad_en_o;
    logic [N-1:0]  stage_valid_o;
    logic [OW-1:0] occupancy_o;
    logic [SW-1:0] stall_cnt_o;

    int check_cnt = 0;
    int error_cnt = 0;

    pipe_load_ctrl #(
        .PIPELINE_STAGE (N),
        .OCC_WIDTH      (OW),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (out_valid_o),
        .flush_i      (flush_i),
        .pipeLoad_en_o(pipeLoad_en_o),
        .stage_valid_o(stage_valid_o),
        .occupancy_o  (occupancy_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1; flush_i = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_en", 32'(pipeLoad_en_o), 32'h0);
        chk("rst_in_ready", 32'(in_ready_o), 32'h0);
        chk("rst_out_valid", 32'(out_valid_o), 32'h0);
        chk("rst_valid", 32'(stage_valid_o), 32'h0);
        chk("rst_occ", 32'(occupancy_o), 32'h0);
        chk("rst_stall", 32'(stall_cnt_o), 32'h0);

        // Single item walks the pipe with out_ready held high.
        rst = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        chk("lat_in_ready", 32'(in_ready_o), 32'h1);
        chk("lat_en0", 32'(pipeLoad_en_o), 32'h01);
        tick();
        in_valid_i = 1'b0;
        #1;
        for (int k = 1; k < N; k++) begin
            chk($sformatf("lat_valid_%0d", k), 32'(stage_valid_o), 32'(1 << (k - 1)));
            chk($sformatf("lat_en_%0d", k), 32'(pipeLoad_en_o), 32'(1 << k));
            chk($sformatf("lat_out_lo_%0d", k), 32'(out_valid_o), 32'h0);
            tick();
        end
        chk("lat_out_hi", 32'(out_valid_o), 32'h1);
        chk("lat_en_idle", 32'(pipeLoad_en_o), 32'h0);
        tick();
        chk("lat_out_pulse", 32'(out_valid_o), 32'h0);

        // Fill against backpressure: 5 accepted, then stalled.
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("fill_in_ready_%0d", i), 32'(in_ready_o), (i < 5) ? 32'h1 : 32'h0);
            tick();
            chk($sformatf("fill_occ_%0d", i), 32'(occupancy_o), (i < 5) ? 32'(i + 1) : 32'd5);
            chk($sformatf("fill_stall_%0d", i), 32'(stall_cnt_o), (i < 5) ? 32'd0 : 32'(i - 4));
        end
        chk("full_en_stall", 32'(pipeLoad_en_o), 32'h0);
        chk("full_valid", 32'(stage_valid_o), 32'h1f);

        // Full pipe streaming: one in, one out.
        out_ready_i = 1'b1;
        #1;
        chk("stream_en", 32'(pipeLoad_en_o), 32'h1f);
        chk("stream_in_ready", 32'(in_ready_o), 32'h1);
        tick();
        chk("stream_occ", 32'(occupancy_o), 32'd5);
        chk("stream_stall", 32'(stall_cnt_o), 32'd2);

        // Flush beats in_valid and out_ready.
        flush_i = 1'b1;
        #1;
        chk("flush_en", 32'(pipeLoad_en_o), 32'h0);
        chk("flush_in_ready", 32'(in_ready_o), 32'h0);
        tick();
        flush_i = 1'b0;
        chk("flush_valid", 32'(stage_valid_o), 32'h0);
        chk("flush_occ", 32'(occupancy_o), 32'd0);
        chk("flush_stall", 32'(stall_cnt_o), 32'd2);

        // Build valids {0,2} then watch the bubble collapse.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; tick();
        in_valid_i = 1'b0; tick();
        in_valid_i = 1'b1; tick();
        in_valid_i = 1'b0;
        chk("bub_valid0", 32'(stage_valid_o), 32'h05);
        #1;
        chk("bub_en1", 32'(pipeLoad_en_o), 32'h0a);
        tick();
        chk("bub_valid1", 32'(stage_valid_o), 32'h0a);
        chk("bub_occ1", 32'(occupancy_o), 32'd2);
        chk("bub_en2", 32'(pipeLoad_en_o), 32'h14);
        tick();
        chk("bub_valid2", 32'(stage_valid_o), 32'h14);
        chk("bub_occ2", 32'(occupancy_o), 32'd2);
        chk("bub_en3", 32'(pipeLoad_en_o), 32'h08);
        chk("bub_stall", 32'(stall_cnt_o), 32'd2);

        // Reset mid-stream with occupancy 3.
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        tick(); tick(); tick();
        chk("mid_occ", 32'(occupancy_o), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_en", 32'(pipeLoad_en_o), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready_o), 32'h0);
        tick();
        rst = 1'b0; in_valid_i = 1'b0;
        chk("mid_rst_valid", 32'(stage_valid_o), 32'h0);
        chk("mid_rst_occ", 32'(occupancy_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_cnt_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mid_no_out_%0d", i), 32'(out_valid_o), 32'h0);
            tick();
        end

        // Long stall: counter saturates at 15.
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i >= 17) begin
                chk($sformatf("sat_stall_%0d", i), 32'(stall_cnt_o), (i - 4 > 15) ? 32'd15 : 32'(i - 4));
            end
        end
        chk("sat_occ", 32'(occupancy_o), 32'd5);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end
endmodule
